// File: rtl/register_file_rw.sv
// 4 x WIDTH register file: one gated write port, two combinational operand read ports,
// and a free-running scan port that dwells SCAN_DWELL cycles on each register.
module register_file_rw #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned SCAN_DWELL = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             c_write_en,
    input  logic [1:0]       c_write_sel,
    input  logic [WIDTH-1:0] write_data,
    input  logic [1:0]       c_left_sel,
    input  logic [1:0]       c_right_sel,
    output logic [WIDTH-1:0] reginputleft,
    output logic [WIDTH-1:0] reginputright,
    output logic [1:0]       scan_index,
    output logic [WIDTH-1:0] scan_data,
    output logic             write_ack
);

    localparam int unsigned     CntW      = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [CntW-1:0] DwellLast = CntW'(SCAN_DWELL - 1);

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic [CntW-1:0]  dwell_q, dwell_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic             write_ack_q, write_ack_d;
    logic             wr_accept;

    assign wr_accept = run & c_write_en;

    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            regs_d[c_write_sel] = write_data;
        end
    end

    // Scan advance is independent of the write path; both may happen on the same edge.
    always_comb begin
        dwell_d    = dwell_q;
        scan_idx_d = scan_idx_q;
        if (run) begin
            if (dwell_q == DwellLast) begin
                dwell_d    = '0;
                scan_idx_d = scan_idx_q + 2'd1;
            end else begin
                dwell_d = dwell_q + CntW'(1);
            end
        end
    end

    assign write_ack_d = wr_accept;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            dwell_q     <= '0;
            scan_idx_q  <= '0;
            write_ack_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            dwell_q     <= dwell_d;
            scan_idx_q  <= scan_idx_d;
            write_ack_q <= write_ack_d;
        end
    end

    // No write bypass: reads see pre-edge state.
    assign reginputleft  = regs_q[c_left_sel];
    assign reginputright = regs_q[c_right_sel];
    assign scan_index    = scan_idx_q;
    assign scan_data     = regs_q[scan_idx_q];
    assign write_ack     = write_ack_q;

endmodule

// File: doc/register_file_rw.md
Name: register_file_rw

Overview:
- 4-entry by 8-bit general-purpose register file (A-D). It is the source end of the operand path: it drives the left and right operands that the ALU input registers latch.
- Accepts ALU or memory results through one write port. Writes are gated by run.
- Adds a free-running debug scan port that cycles through all registers, one at a time, for the display and board logic.

Parameters:
WIDTH, 8, register and data width in bits
NUM_REGS, 4, number of registers; fixed at 4 because selects are 2 bits
SCAN_DWELL, 4, clock cycles each register stays on the scan port (must be >= 1)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
run  input  1  global execute enable; gates writes and scan advance
c_write_en  input  1  register write enable
c_write_sel  input  2  destination register index for a write
write_data  input  WIDTH  value to be written
c_left_sel  input  2  register index for the left read port
c_right_sel  input  2  register index for the right read port
reginputleft  output  WIDTH  left operand, combinational read
reginputright  output  WIDTH  right operand, combinational read
scan_index  output  2  register index currently shown on the scan port
scan_data  output  WIDTH  contents of reg[scan_index]
write_ack  output  1  registered one-cycle pulse after each accepted write

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0
  - scan_index = 0, dwell counter = 0
  - write_ack = 0
  - consequently reginputleft = reginputright = scan_data = 0
  - reset asserted mid-write discards the write; no partial update
- Write:
  - accepted on a rising edge when reset=1, run=1 and c_write_en=1
  - reg[c_write_sel] <= write_data; other registers hold
  - if run=0 or c_write_en=0, every register holds
- write_ack:
  - registered; equals 1 for exactly the cycle after an accepted write, otherwise 0
  - back-to-back accepted writes hold it high continuously
- Read ports:
  - purely combinational muxes of current register state; zero latency
  - read-during-write to the same index returns the OLD value until the edge; the new value is visible the cycle after (no bypass)
  - left and right may select the same register; both outputs then show the same value
- Scan:
  - dwell counter increments on each edge with run=1
  - when it reaches SCAN_DWELL-1, it resets to 0 and scan_index increments, wrapping 3 -> 0
  - run=0 freezes counter and index
  - scan_data is combinational from reg[scan_index], so it reflects a write the cycle after that write
- Simultaneous events:
  - a write to the scanned register in the same edge as a scan advance: the new index is shown and the write still lands
  - no interaction between the two
- Width rules:
  - no arithmetic on data; values are stored verbatim
  - selects are 2 bits, so every index is valid and there is no out-of-range case

Test Plan:
1. Reset then release. Assert reset=0 mid-cycle -> all outputs 0 immediately, no clock needed. Release and read all indices -> 0x00.
2. run=1, writes A=0x11, B=0x22, C=0x33, D=0xFF on consecutive cycles -> write_ack high for 4 cycles, starting one cycle after the first write. Afterwards, left_sel=3/right_sel=1 -> reginputleft=0xFF, reginputright=0x22.
3. run=0 with c_write_en=1, sel=2, data=0xAA -> C stays 0x33, write_ack stays 0, scan frozen.
4. Read-during-write: right_sel=0, write A=0x5C -> reginputright=0x11 before the edge, 0x5C after. Left and right both select B -> both 0x22.
5. Scan with SCAN_DWELL=4, run=1 continuous -> scan_index advances every 4 cycles through 0,1,2,3,0. scan_data tracks the selected register, including a write landing while that register is shown.
6. Assert reset during an active write edge -> target register reads 0 after release and write_ack stays 0.
